// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared write-back types and register-file constants
package rv_wb_pkg;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests with wrap-bit full/empty detection
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic    [AW:0] wp;
    logic    [AW:0] rp;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    // pointer update; requests against full/empty are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    // storage write, no reset needed since empty masks stale data
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and long-latency write-backs into one registered write port; REGFILE_WB_SCOREBOARD_EN adds the pending-register scoreboard
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_stall,
    input  logic             ll_valid,
    output logic             ll_ready,
    input  logic [4:0]       ll_rd,
    input  logic [XLEN-1:0]  ll_data,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    output logic [NREGS-1:0] pending,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data
);

    localparam int CW = $clog2(MAX_STALL + 1);

    wb_req_t         ll_req;
    wb_req_t         head;
    logic            full;
    logic            empty;
    logic            push;
    logic            g_ll;
    logic            g_alu;
    logic            starve;
    logic [CW-1:0]   cnt;

    assign ll_req   = '{rd: ll_rd, data: ll_data};
    assign ll_ready = !full;
    assign push     = ll_valid && !full;
    assign g_ll     = !empty && (alu_stall || !alu_valid);
    assign g_alu    = alu_valid && !g_ll;
    assign starve   = g_alu && !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (g_ll),
        .din   (ll_req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // count ALU wins over a waiting LL entry; the MAX_STALL-th win stalls ALU for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            alu_stall <= 1'b0;
        end else begin
            cnt       <= starve ? cnt + 1'b1 : '0;
            alu_stall <= starve && (cnt == CW'(MAX_STALL - 1));
        end
    end

    // register the granted write; rd 0 entries are consumed without writing
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_rd   <= REG_ZERO;
            wb_data <= '0;
        end else begin
            wb_we   <= (g_alu && alu_rd != REG_ZERO) || (g_ll && head.rd != REG_ZERO);
            wb_rd   <= g_alu ? alu_rd : g_ll ? head.rd : REG_ZERO;
            wb_data <= g_alu ? alu_data : g_ll ? head.data : '0;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] set_m;
    logic [NREGS-1:0] clr_m;

    // issue sets and LL pop clears; set applied after clear so it wins, bit 0 never set
    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (iss_valid) set_m[iss_rd] = 1'b1;
        if (g_ll) clr_m[head.rd] = 1'b1;
        set_m[0] = 1'b0;
    end

    // pending register
    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else pend_q <= (pend_q & ~clr_m) | set_m;
    end

    assign pending = pend_q;
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_rd};
    assign pending    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the write-back arbiter
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        ll_valid = 1'b0;
    logic        ll_ready;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [31:0] pending;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .pending   (pending),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    // every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got rd=%0d data=%h, expected no write", wb_rd, wb_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wb_rd, wb_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL wb_order got rd=%0d data=%h, expected rd=%0d data=%h",
                             wb_rd, wb_data, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        if (rd != 5'd0) exp_q.push_back({rd, d});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got %b expected 0", wb_we); end
        if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d expected 0", wb_rd); end
        if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h expected 0", wb_data); end
        if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_alu_stall got %b expected 0", alu_stall); end
        if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h expected 0", pending); end
        if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ll_ready got %b expected 1", ll_ready); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive_alu(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        checks += 3;
        if (wb_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b expected 1", wb_we); end
        if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d expected 5", wb_rd); end
        if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h expected deadbeef", wb_data); end
        drive_alu(5'd0, 32'hCAFE0000);
        tick();
        alu_valid = 1'b0;
        checks++;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL alu_rd0_we got %b expected 0", wb_we); end
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) != 0) drive_alu(5'($urandom_range(0, 31)), $urandom);
            else alu_valid = 1'b0;
            tick();
        end
        alu_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL alu_drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_ll();
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        tick();
        iss_valid = 1'b0;
        checks++;
        if (pending !== (SB ? 32'h80 : 32'h0)) begin errors++; $display("FAIL ll_pend_set got %h expected %h", pending, SB ? 32'h80 : 32'h0); end
        ll_valid = 1'b1;
        ll_rd    = 5'd7;
        ll_data  = 32'h12345678;
        exp_q.push_back({5'd7, 32'h12345678});
        tick();
        ll_valid = 1'b0;
        checks += 2;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL ll_early_we got %b expected 0", wb_we); end
        if (pending !== (SB ? 32'h80 : 32'h0)) begin errors++; $display("FAIL ll_pend_hold got %h expected %h", pending, SB ? 32'h80 : 32'h0); end
        tick();
        checks += 4;
        if (wb_we !== 1'b1) begin errors++; $display("FAIL ll_we got %b expected 1", wb_we); end
        if (wb_rd !== 5'd7) begin errors++; $display("FAIL ll_rd got %0d expected 7", wb_rd); end
        if (wb_data !== 32'h12345678) begin errors++; $display("FAIL ll_data got %h expected 12345678", wb_data); end
        if (pending !== 32'h0) begin errors++; $display("FAIL ll_pend_clr got %h expected 0", pending); end
        ll_valid = 1'b1;
        ll_rd    = 5'd0;
        ll_data  = 32'h0BADF00D;
        tick();
        ll_valid = 1'b0;
        tick();
        checks += 2;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL ll_rd0_we got %b expected 0", wb_we); end
        if (ll_ready !== 1'b1) begin errors++; $display("FAIL ll_rd0_ready got %b expected 1", ll_ready); end
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ll_drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(10 + i), 32'hA000 + i);
            ll_valid = 1'b1;
            ll_rd    = 5'(16 + i);
            ll_data  = 32'hB000 + i;
            tick();
        end
        checks++;
        if (ll_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b expected 0", ll_ready); end
        alu_valid = 1'b0;
        ll_rd     = 5'd31;
        ll_data   = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) exp_q.push_back({5'(16 + i), 32'hB000 + i});
        tick();
        ll_valid = 1'b0;
        checks++;
        if (ll_ready !== 1'b1) begin errors++; $display("FAIL full_reready got %b expected 1", ll_ready); end
        repeat (5) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 12; c++) begin
            if (c != 9) drive_alu(5'(c + 1), 32'hC000 + c);
            else begin
                alu_valid = 1'b0;
                exp_q.push_back({5'd9, 32'h55AA55AA});
            end
            ll_valid = (c == 0);
            ll_rd    = 5'd9;
            ll_data  = 32'h55AA55AA;
            tick();
            checks++;
            if (alu_stall !== (c == 8)) begin errors++; $display("FAIL starve_stall cycle %0d got %b expected %b", c, alu_stall, c == 8); end
        end
        alu_valid = 1'b0;
        ll_valid  = 1'b0;
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL starve_drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_collision();
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        ll_valid  = 1'b1;
        ll_rd     = 5'd3;
        ll_data   = 32'h33333333;
        exp_q.push_back({5'd3, 32'h33333333});
        tick();
        ll_valid = 1'b0;
        checks++;
        if (pending !== (SB ? 32'h8 : 32'h0)) begin errors++; $display("FAIL coll_set got %h expected %h", pending, SB ? 32'h8 : 32'h0); end
        tick();
        iss_valid = 1'b0;
        checks += 2;
        if (wb_rd !== 5'd3) begin errors++; $display("FAIL coll_wb_rd got %0d expected 3", wb_rd); end
        if (pending !== (SB ? 32'h8 : 32'h0)) begin errors++; $display("FAIL coll_setwins got %h expected %h", pending, SB ? 32'h8 : 32'h0); end
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        tick();
        iss_valid = 1'b0;
        checks++;
        if (pending !== (SB ? 32'h8 : 32'h0)) begin errors++; $display("FAIL coll_rd0 got %h expected %h", pending, SB ? 32'h8 : 32'h0); end
        ll_valid = 1'b1;
        ll_data  = 32'h33330000;
        exp_q.push_back({5'd3, 32'h33330000});
        tick();
        ll_valid = 1'b0;
        tick();
        checks++;
        if (pending !== 32'h0) begin errors++; $display("FAIL coll_clr got %h expected 0", pending); end
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL coll_drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'(20 + i), 32'hD000 + i);
            ll_valid  = 1'b1;
            ll_rd     = 5'(24 + i);
            ll_data   = 32'hE000 + i;
            iss_valid = 1'b1;
            iss_rd    = 5'(24 + i);
            tick();
        end
        alu_valid = 1'b0;
        ll_valid  = 1'b0;
        iss_valid = 1'b0;
        checks++;
        if (pending !== (SB ? 32'h0700_0000 : 32'h0)) begin errors++; $display("FAIL mid_pend got %h expected %h", pending, SB ? 32'h0700_0000 : 32'h0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 6;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL mid_wb_we got %b expected 0", wb_we); end
        if (wb_rd !== 5'd0) begin errors++; $display("FAIL mid_wb_rd got %0d expected 0", wb_rd); end
        if (wb_data !== 32'h0) begin errors++; $display("FAIL mid_wb_data got %h expected 0", wb_data); end
        if (alu_stall !== 1'b0) begin errors++; $display("FAIL mid_alu_stall got %b expected 0", alu_stall); end
        if (pending !== 32'h0) begin errors++; $display("FAIL mid_pending got %h expected 0", pending); end
        if (ll_ready !== 1'b1) begin errors++; $display("FAIL mid_ll_ready got %b expected 1", ll_ready); end
        repeat (8) tick();
        checks += 2;
        if (wb_we !== 1'b0) begin errors++; $display("FAIL mid_stale_we got %b expected 0", wb_we); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ll();
        test_fifo_full();
        test_starvation();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
